// File: rtl/operand_entry.sv
// operand_entry: collects two 4-bit operands from the slide switches.
// Each debounced key press advances ENTER_A -> ENTER_B -> SHOW -> ENTER_A.
// key_n is synchronized, then debounced. A registered falling-edge detect
// on the debounced level produces a one-cycle press pulse. The operand FSM
// samples sw on the edge where press is high.
// press is a plain pulse with no ready/acknowledge. Every pulse is consumed
// on the clock edge where it is high.
module operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic [3:0] sw,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [1:0] stage,
  output logic       valid,
  output logic       press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ENTER_A = 2'b00,
    ENTER_B = 2'b01,
    SHOW    = 2'b10
  } state_t;

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q;
  logic          press_q;
  state_t        state_q, state_d;
  logic [3:0]    a_q, a_d, b_q, b_d;
  logic          valid_q, valid_d;

  // Two-flop synchronizer for the asynchronous push button.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive cycles where the synchronized level differs from the stable level.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state and the registered falling-edge detect of the stable level.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
      prev_q   <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      prev_q   <= stable_q;
      press_q  <= prev_q & ~stable_q;
    end
  end

  // Operand FSM next state: acts only on a press; illegal encoding recovers to ENTER_A.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    case (state_q)
      ENTER_A: begin
        if (press_q) begin
          a_d     = sw;
          state_d = ENTER_B;
        end
      end
      ENTER_B: begin
        if (press_q) begin
          b_d     = sw;
          valid_d = 1'b1;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (press_q) begin
          valid_d = 1'b0;
          state_d = ENTER_A;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ENTER_A;
      end
    endcase
  end

  // Operand FSM registers; reset overrides any press on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ENTER_A;
      a_q     <= 4'h0;
      b_q     <= 4'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign stage = state_q;
  assign valid = valid_q;
  assign press = press_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb_operand_entry: drives operand_entry with directed and random key/switch
// activity. It compares every output on every cycle against a behavioural
// model: a two-sample delay line, a run-length debounce rule, and an operand
// state machine.
module tb_operand_entry;

  localparam int DEB = 4;

  logic       clk;
  logic       reset;
  logic       key_n;
  logic [3:0] sw;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] stage;
  logic       valid;
  logic       press;

  operand_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .sw    (sw),
    .a     (a),
    .b     (b),
    .stage (stage),
    .valid (valid),
    .press (press)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // reference model state
  logic       kq[$];
  logic       m_stable;
  int         m_run;
  logic       m_fell_prev;
  logic       m_press;
  logic [3:0] m_a, m_b;
  int         m_stage;
  logic       m_valid;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_press = 0;
  int first_press_cyc = -1;

  // scoreboard compare
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock edge of the reference model, using the inputs sampled on that edge.
  task automatic model_edge(input logic k, input logic [3:0] s, input logic r);
    logic s_sync;
    logic fell;
    if (r) begin
      kq.delete();
      kq.push_back(1'b1);
      kq.push_back(1'b1);
      m_stable    = 1'b1;
      m_run       = 0;
      m_fell_prev = 1'b0;
      m_press     = 1'b0;
      m_a         = 4'h0;
      m_b         = 4'h0;
      m_stage     = 0;
      m_valid     = 1'b0;
    end else begin
      if (m_press) begin
        case (m_stage)
          0: begin m_a = s; m_stage = 1; end
          1: begin m_b = s; m_valid = 1'b1; m_stage = 2; end
          default: begin m_valid = 1'b0; m_stage = 0; end
        endcase
      end
      s_sync = kq.pop_front();
      kq.push_back(k);
      fell = 1'b0;
      if (s_sync != m_stable) begin
        m_run++;
        if (m_run == DEB) begin
          m_stable = s_sync;
          m_run    = 0;
          fell     = (s_sync == 1'b0);
        end
      end else begin
        m_run = 0;
      end
      m_press     = m_fell_prev;
      m_fell_prev = fell;
    end
  endtask

  // driver: apply inputs for one cycle, advance model, check all outputs
  task automatic tick(input logic k, input logic [3:0] s, input logic r);
    key_n = k;
    sw    = s;
    reset = r;
    @(posedge clk);
    model_edge(k, s, r);
    #1;
    cyc++;
    check_eq("press", 32'(press), 32'(m_press));
    check_eq("a",     32'(a),     32'(m_a));
    check_eq("b",     32'(b),     32'(m_b));
    check_eq("stage", 32'(stage), 32'(m_stage));
    check_eq("valid", 32'(valid), 32'(m_valid));
    if (press === 1'b1) begin
      n_press++;
      if (first_press_cyc < 0) first_press_cyc = cyc;
    end
  endtask

  task automatic press_key(input logic [3:0] s);
    for (int i = 0; i < 10; i++) tick(1'b0, s, 1'b0);
    for (int i = 0; i < 8; i++)  tick(1'b1, s, 1'b0);
  endtask

  initial begin
    logic [3:0] save_a, save_b;
    int first_low;
    int guard;
    logic k;
    int len;

    key_n = 1'b1;
    sw    = 4'h0;
    reset = 1'b1;

    // reset state
    tick(1'b1, 4'h0, 1'b1);
    tick(1'b1, 4'h0, 1'b1);
    check_eq("rst_a", 32'(a), 32'h0);
    check_eq("rst_b", 32'(b), 32'h0);
    check_eq("rst_stage", 32'(stage), 32'h0);
    check_eq("rst_valid", 32'(valid), 32'h0);
    check_eq("rst_press", 32'(press), 32'h0);
    for (int i = 0; i < 4; i++) tick(1'b1, 4'h0, 1'b0);

    // short glitch is ignored
    n_press = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, 4'h7, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b1, 4'h7, 1'b0);
    check_eq("glitch_npress", 32'(n_press), 32'd0);
    check_eq("glitch_stage", 32'(stage), 32'h0);

    // two operand entries
    press_key(4'h3);
    check_eq("first_a", 32'(a), 32'h3);
    check_eq("first_stage", 32'(stage), 32'h1);
    press_key(4'h5);
    check_eq("second_b", 32'(b), 32'h5);
    check_eq("second_valid", 32'(valid), 32'h1);
    check_eq("second_stage", 32'(stage), 32'h2);

    // SHOW -> ENTER_A keeps operands, then overwrite a
    press_key(4'h0);
    check_eq("show_valid", 32'(valid), 32'h0);
    check_eq("show_stage", 32'(stage), 32'h0);
    check_eq("show_a", 32'(a), 32'h3);
    check_eq("show_b", 32'(b), 32'h5);
    press_key(4'hF);
    check_eq("new_a", 32'(a), 32'hF);

    // long hold with release bounce: one press at fixed latency
    n_press = 0;
    first_press_cyc = -1;
    first_low = cyc + 1;
    for (int i = 0; i < 100; i++) tick(1'b0, 4'h2, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick(1'b1, 4'h2, 1'b0);
      tick(1'b1, 4'h2, 1'b0);
      tick(1'b0, 4'h2, 1'b0);
      tick(1'b0, 4'h2, 1'b0);
    end
    for (int i = 0; i < 12; i++) tick(1'b1, 4'h2, 1'b0);
    check_eq("hold_npress", 32'(n_press), 32'd1);
    check_eq("hold_latency", 32'(first_press_cyc - first_low), 32'(DEB + 2));

    // sw activity without key has no effect
    save_a = a;
    save_b = b;
    for (int i = 0; i < 32; i++) tick(1'b1, 4'(i), 1'b0);
    check_eq("sw_only_a", 32'(a), 32'(save_a));
    check_eq("sw_only_b", 32'(b), 32'(save_b));

    // reset on the same edge as a press in ENTER_B
    for (int j = 0; j < 3; j++) if (m_stage != 1) press_key(4'h6);
    check_eq("pre_rst_stage", 32'(stage), 32'h1);
    guard = 0;
    while (m_press !== 1'b1 && guard < 20) begin
      tick(1'b0, 4'h9, 1'b0);
      guard++;
    end
    check_eq("pre_rst_press", 32'(press), 32'h1);
    tick(1'b0, 4'h9, 1'b1);
    check_eq("rstp_a", 32'(a), 32'h0);
    check_eq("rstp_b", 32'(b), 32'h0);
    check_eq("rstp_stage", 32'(stage), 32'h0);
    check_eq("rstp_valid", 32'(valid), 32'h0);

    // key held through reset release: single press at fixed latency
    n_press = 0;
    first_press_cyc = -1;
    first_low = cyc + 1;
    for (int i = 0; i < 20; i++) tick(1'b0, 4'hC, 1'b0);
    check_eq("held_rst_npress", 32'(n_press), 32'd1);
    check_eq("held_rst_latency", 32'(first_press_cyc - first_low), 32'(DEB + 2));
    check_eq("held_rst_a", 32'(a), 32'hC);
    for (int i = 0; i < 10; i++) tick(1'b1, 4'hC, 1'b0);

    // randomized key segments, random sw, occasional reset
    for (int seg = 0; seg < 300; seg++) begin
      k   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        tick(k, 4'($urandom_range(0, 15)), ($urandom_range(0, 199) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 The block SHALL have a parameter DEBOUNCE_CYCLES, default 500000, giving the number of consecutive stable clk cycles needed to accept a key level change (10 ms at 50 MHz).
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have a port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have a port key_n, input, 1 bit: push button, active-low (0 = pressed), asynchronous to clk.
REQ-005 The block SHALL have a port sw, input, 4 bits: operand value from the slide switches, treated as quasi-static.
REQ-006 The block SHALL have a port a, output, 4 bits: registered first operand, fed to the math operator stage.
REQ-007 The block SHALL have a port b, output, 4 bits: registered second operand, fed to the math operator stage.
REQ-008 The block SHALL have a port stage, output, 2 bits: current FSM state; 00 = ENTER_A, 01 = ENTER_B, 10 = SHOW.
REQ-009 The block SHALL have a port valid, output, 1 bit: high while a and b both hold committed operands.
REQ-010 The block SHALL have a port press, output, 1 bit: one-cycle pulse per accepted key press, for debug and test.

Function
REQ-011 key_n SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debouncer SHALL hold a stable level and a counter; the counter clears whenever the synchronized level equals the stable level.
REQ-013 The debouncer SHALL, while the levels differ, increment the counter each cycle and update the stable level on the cycle the counter reaches DEBOUNCE_CYCLES-1, then clear the counter.
REQ-014 Any synchronized pulse or glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave the stable level unchanged; bounce on release SHALL likewise be ignored.
REQ-015 The counter width SHALL be $clog2(DEBOUNCE_CYCLES)+1, and the counter SHALL never wrap.
REQ-016 press SHALL pulse for exactly one cycle when the stable level goes from released (1) to pressed (0); a held key SHALL give exactly one pulse.
REQ-017 press SHALL assert DEBOUNCE_CYCLES+2 cycles after the first rising edge on which key_n is sampled low and held (±0 cycles).
REQ-018 The FSM SHALL act on the edge where press=1, sampling sw on that same edge.
REQ-019 In ENTER_A, a press SHALL set a <= sw and move to ENTER_B; b and valid stay unchanged.
REQ-020 In ENTER_B, a press SHALL set b <= sw, set valid <= 1, and move to SHOW.
REQ-021 In SHOW, a press SHALL set valid <= 0 and move to ENTER_A; a and b keep their old values until overwritten.
REQ-022 With no press, stage, a, b and valid SHALL hold their values.
REQ-023 State encoding 11 is unreachable; if entered, the FSM SHALL go to ENTER_A on the next edge with valid <= 0.
REQ-024 a, b, stage and valid SHALL be driven directly from registers, with no combinational path from sw or key_n.
REQ-025 sw changes SHALL have no effect except on a press edge.

Reset
REQ-026 On a clk edge with reset=1, the block SHALL set a=0, b=0, valid=0, stage=ENTER_A, press=0, counter=0, synchronizer flops=1 and stable level=1 (released).
REQ-027 reset SHALL take priority over a press pulse on the same edge.
REQ-028 A key held through reset release SHALL be accepted as a single press DEBOUNCE_CYCLES+2 cycles after release.
REQ-029 A reset mid-debounce SHALL discard the partial count.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset, then sw=3, press key_n for 10 cycles, then sw=5, press again -> a=3 after the first press; b=5, valid=1 and stage=10 after the second.
REQ-031 key_n low for 3 cycles, then high -> press never asserts; stage stays 00.
REQ-032 key_n low held for 100 cycles with 2-cycle bounces on release -> exactly one press pulse, asserted 6 cycles after the first low sample.
REQ-033 In SHOW with a=3 and b=5, one press -> valid=0, stage=00, a=3 and b=5 retained; next press with sw=F -> a=F.
REQ-034 reset asserted on the same edge as press while in ENTER_B -> a=0, b=0, stage=00, valid=0.
REQ-035 sw toggles every cycle from 0 to F with no key activity -> a and b unchanged.
